// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor (FIPS-197 InvCipher): forward key expansion to rk10,
// then ten inverse rounds at one per clock, with round keys derived backwards on the fly.
module aes_decrypt_core #(
  parameter bit ZEROISE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] Block,
  input  logic [127:0] Key,
  output logic         busy,
  output logic         done,
  output logic [127:0] Result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_ARK,
    S_ROUND,
    S_DONE
  } state_t;

  state_t       state, state_nx;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rcnt;
  logic [127:0] fwd_rk;
  logic [127:0] inv_rk;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Last word is recovered first since the first word depends on it through SubWord.
  function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int unsigned i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        b[r + 4*c] = inv_sbox(a[r + 4*((c + 4 - r) % 4)]) ^ k[127 - 8*(r + 4*c) -: 8];
      end
    end
    if (mix) begin
      for (int unsigned c = 0; c < 4; c++) begin
        c0 = b[4*c];
        c1 = b[4*c + 1];
        c2 = b[4*c + 2];
        c3 = b[4*c + 3];
        b[4*c]     = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
        b[4*c + 1] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
        b[4*c + 2] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
        b[4*c + 3] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
      end
    end
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    return o;
  endfunction

  always_comb begin
    fwd_rk    = fwd_key(rk, rcon_of(rcnt));
    inv_rk    = inv_key(rk, rcon_of(rcnt + 4'd1));
    round_out = inv_round(st, inv_rk, rcnt != 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_KEXP;
      S_KEXP: begin
        busy = 1'b1;
        if (rcnt == 4'd10) state_nx = S_ARK;
      end
      S_ARK: begin
        busy     = 1'b1;
        state_nx = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (rcnt == 4'd0) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = start ? S_KEXP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= '0;
      rk     <= '0;
      rcnt   <= '0;
      Result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            st   <= Block;
            rk   <= Key;
            rcnt <= 4'd1;
          end
        end
        S_KEXP: begin
          rk   <= fwd_rk;
          rcnt <= rcnt + 4'd1;
        end
        S_ARK: begin
          st   <= st ^ rk;
          rcnt <= 4'd9;
        end
        S_ROUND: begin
          st <= round_out;
          rk <= inv_rk;
          if (rcnt == 4'd0) Result <= round_out;
          else              rcnt   <= rcnt - 4'd1;
        end
        S_DONE: begin
          // A start here launches the next block directly; otherwise optionally scrub secrets.
          if (start) begin
            st   <= Block;
            rk   <= Key;
            rcnt <= 4'd1;
          end else if (ZEROISE) begin
            st   <= '0;
            rk   <= '0;
            rcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
